// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with locked-sequence hold and SPLIT masking.
// Grant, owner index and lock flag toward the bus are all registered.
module ahb_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW            = $clog2(NO_OF_MASTERS)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [NO_OF_MASTERS-1:0] HSPLIT,
    input  logic                     HREADY,
    input  logic [1:0]               HTRANS,
    input  logic [1:0]               HRESP,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]            HMASTER,
    output logic                     HMASTLOCK
);
    localparam logic [1:0] TR_BUSY  = 2'b01;
    localparam logic [1:0] TR_SEQ   = 2'b11;
    localparam logic [1:0] RSP_SPLIT = 2'b11;

    typedef enum logic [1:0] {ST_DFLT, ST_NORM, ST_LOCK} state_t;

    state_t                     state_q, state_d;
    logic [NO_OF_MASTERS-1:0]   grant_q, grant_d;
    logic [MW-1:0]              gidx_q, gidx_d;
    logic [MW-1:0]              rr_q, rr_d;
    logic [NO_OF_MASTERS-1:0]   mask_q, mask_d;
    logic [MW-1:0]              master_q;
    logic                       mastlock_q;

    logic [NO_OF_MASTERS-1:0]   eligible;
    logic                       split_set, owner_req, owner_lock;
    logic                       burst_hold, lock_exit, arb_ok;
    logic [MW-1:0]              winner;

    assign split_set  = HREADY && (HRESP == RSP_SPLIT);
    assign owner_req  = HBUSREQ[gidx_q];
    assign owner_lock = HLOCK[gidx_q];

    // A split set on the same edge as a resume for that master takes priority.
    for (genvar gi = 0; gi < NO_OF_MASTERS; gi++) begin : g_mask
        assign mask_d[gi] = (split_set && (master_q == MW'(gi))) ||
                            (mask_q[gi] && !HSPLIT[gi]);
    end

    assign eligible   = HBUSREQ & ~mask_d;
    assign burst_hold = ((HTRANS == TR_BUSY) || (HTRANS == TR_SEQ)) && owner_req;
    assign lock_exit  = (state_q == ST_LOCK) && (!owner_lock || !owner_req);
    assign arb_ok     = HREADY &&
                        (split_set || (((state_q != ST_LOCK) || lock_exit) && !burst_hold));

    // Scan from the farthest candidate back to rr+1 so the nearest eligible one wins.
    always_comb begin
        winner = MW'(DEFAULT_MASTER);
        for (int k = NO_OF_MASTERS; k >= 1; k--) begin
            if (eligible[(int'(rr_q) + k) % NO_OF_MASTERS]) begin
                winner = MW'((int'(rr_q) + k) % NO_OF_MASTERS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        if (arb_ok) begin
            gidx_d          = winner;
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            if (|eligible) begin
                rr_d    = winner;
                state_d = HLOCK[winner] ? ST_LOCK : ST_NORM;
            end else begin
                state_d = ST_DFLT;
            end
        end else if (HREADY && lock_exit) begin
            state_d = ST_NORM;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q                 <= ST_DFLT;
            grant_q                 <= '0;
            grant_q[DEFAULT_MASTER] <= 1'b1;
            gidx_q                  <= MW'(DEFAULT_MASTER);
            rr_q                    <= MW'(DEFAULT_MASTER);
            mask_q                  <= '0;
            master_q                <= MW'(DEFAULT_MASTER);
            mastlock_q              <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            mask_q  <= mask_d;
            if (HREADY) begin
                master_q   <= gidx_q;
                mastlock_q <= owner_lock;
            end
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: rotation, burst hold, locking, SPLIT masking, reset.
module tb_ahb_arbiter;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01, SPLIT = 2'b11;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] HBUSREQ, HLOCK, HSPLIT;
    logic       HREADY;
    logic [1:0] HTRANS, HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int checks = 0;
    int errors = 0;

    ahb_arbiter #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HSPLIT   (HSPLIT),
        .HREADY   (HREADY),
        .HTRANS   (HTRANS),
        .HRESP    (HRESP),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        check("onehot", 32'($onehot(HGRANT)), 32'd1);
    endtask

    initial begin
        HRESETn = 1'b0; HBUSREQ = '0; HLOCK = '0; HSPLIT = '0;
        HREADY = 1'b1; HTRANS = IDLE; HRESP = OKAY;
        tick(); tick();
        check("rst_grant", 32'(HGRANT), 32'h1);
        check("rst_master", 32'(HMASTER), 32'd0);
        check("rst_lock", 32'(HMASTLOCK), 32'd0);

        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_grant", 32'(HGRANT), 32'h1);
            check("idle_master", 32'(HMASTER), 32'd0);
            check("idle_lock", 32'(HMASTLOCK), 32'd0);
        end

        HBUSREQ = 4'b1111; HTRANS = NONSEQ;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("rr_grant", 32'(HGRANT), 32'(1 << (k % 4)));
            check("rr_master", 32'(HMASTER), 32'((k - 1) % 4));
        end

        HBUSREQ = 4'b0100;
        tick();
        check("m2_grant", 32'(HGRANT), 32'h4);
        HBUSREQ = 4'b0110; HTRANS = SEQ;
        for (int b = 1; b <= 4; b++) begin
            HREADY = (b != 2);
            tick();
            check("burst_grant", 32'(HGRANT), 32'h4);
        end
        check("burst_master", 32'(HMASTER), 32'd2);
        HREADY = 1'b1; HTRANS = IDLE;
        tick();
        check("burst_end_grant", 32'(HGRANT), 32'h2);

        HBUSREQ = 4'b0010; HLOCK = 4'b0010;
        tick();
        check("lock_grant", 32'(HGRANT), 32'h2);
        check("lock_master", 32'(HMASTER), 32'd1);
        check("lock_mastlock", 32'(HMASTLOCK), 32'd1);
        HBUSREQ = 4'b1010; HTRANS = NONSEQ;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_hold_grant", 32'(HGRANT), 32'h2);
            check("lock_hold_mastlock", 32'(HMASTLOCK), 32'd1);
        end
        HLOCK = 4'b0000;
        tick();
        check("unlock_grant", 32'(HGRANT), 32'h8);
        check("unlock_mastlock", 32'(HMASTLOCK), 32'd0);
        tick();
        check("unlock_master", 32'(HMASTER), 32'd3);

        HBUSREQ = 4'b0100;
        tick(); tick();
        check("pre_split_master", 32'(HMASTER), 32'd2);
        check("pre_split_grant", 32'(HGRANT), 32'h4);
        HRESP = SPLIT;
        tick();
        check("split_grant", 32'(HGRANT), 32'h1);
        HRESP = OKAY;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("split_masked_grant", 32'(HGRANT), 32'h1);
        end
        HSPLIT = 4'b0100;
        tick();
        check("resume_grant", 32'(HGRANT), 32'h4);
        HSPLIT = 4'b0000;

        HBUSREQ = 4'b0010;
        tick(); tick();
        check("pre_race_master", 32'(HMASTER), 32'd1);
        HRESP = SPLIT; HSPLIT = 4'b0010;
        tick();
        check("race_grant", 32'(HGRANT), 32'h1);
        HRESP = OKAY; HSPLIT = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("race_masked_grant", 32'(HGRANT), 32'h1);
        end

        HBUSREQ = 4'b0100; HRESP = ERROR;
        tick();
        check("error_grant", 32'(HGRANT), 32'h4);

        HRESP = OKAY; HBUSREQ = 4'b1111; HTRANS = SEQ; HLOCK = 4'b0100;
        HRESETn = 1'b0;
        tick();
        check("midrst_grant", 32'(HGRANT), 32'h1);
        check("midrst_master", 32'(HMASTER), 32'd0);
        check("midrst_lock", 32'(HMASTLOCK), 32'd0);
        HRESETn = 1'b1; HBUSREQ = 4'b0010; HLOCK = 4'b0000; HTRANS = NONSEQ;
        tick();
        check("post_rst_grant", 32'(HGRANT), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Central AHB bus arbiter that shares the single address/data bus between NO_OF_MASTERS requesters. It implements round-robin priority with locked-sequence hold and SPLIT masking. It drives HGRANT, HMASTER and HMASTLOCK toward the masters, slaves and address/write-data muxes, and consumes HBUSREQ, HLOCK and HSPLIT plus the bus-global HREADY/HTRANS/HRESP.

Parameters:
NO_OF_MASTERS, 4, number of bus masters (2..16)
DEFAULT_MASTER, 0, master granted when no eligible request exists; also the reset owner

Ports:
HCLK  input  1  bus clock; all logic on rising edge
HRESETn  input  1  reset; synchronous and active-low
HBUSREQ  input  NO_OF_MASTERS  per-master bus request
HLOCK  input  NO_OF_MASTERS  per-master locked-transfer request
HSPLIT  input  NO_OF_MASTERS  OR of slave split-resume bits; bit i unmasks master i
HREADY  input  1  bus-global transfer-complete
HTRANS  input  2  transfer type of current address phase (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HRESP  input  2  current response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11)
HGRANT  output  NO_OF_MASTERS  one-hot grant, registered
HMASTER  output  $clog2(NO_OF_MASTERS)  owner of current address phase, registered
HMASTLOCK  output  1  current address phase is locked, registered

Behaviour:
- Reset (HRESETn=0 at edge): HGRANT = one-hot DEFAULT_MASTER; HMASTER = DEFAULT_MASTER; HMASTLOCK = 0; split_mask = 0; rr_ptr = DEFAULT_MASTER; FSM = DFLT. Reset mid-burst discards all state the same way.
- eligible = HBUSREQ & ~split_mask. g = index of current HGRANT.
- FSM states and meaning:
  - DFLT: no eligible request; DEFAULT_MASTER granted.
  - NORM: a requesting master granted.
  - LOCK: the granted master holds HLOCK[g]=1 and HBUSREQ[g]=1.
- Arbitration point (arb_ok): HREADY=1 and FSM!=LOCK and (HTRANS not in {BUSY,SEQ} or HBUSREQ[g]=0). Grant never changes when HREADY=0.
- At arb_ok, the winner is the first eligible index searching (rr_ptr+1) mod N upward, wrapping, and ending with rr_ptr itself. A current owner still requesting therefore loses to any other eligible master. With no eligible master, the winner is DEFAULT_MASTER and FSM goes to DFLT.
- On arb_ok: HGRANT <= one-hot(winner); rr_ptr <= winner when eligible; FSM <= LOCK if HLOCK[winner] & eligible[winner], else NORM/DFLT.
- LOCK exit: at HREADY=1 with HLOCK[g]=0 or HBUSREQ[g]=0, FSM returns to NORM and normal arbitration applies that same cycle.
- Ownership handover: on every edge with HREADY=1, HMASTER <= g and HMASTLOCK <= HLOCK[g]. HMASTER therefore trails HGRANT by one completed transfer.
- Latency on a free bus (HREADY=1, HTRANS=IDLE):
  - HBUSREQ sampled at edge t.
  - HGRANT valid after edge t.
  - HMASTER valid after edge t+1.
- SPLIT handling:
  - On an edge with HREADY=1 and HRESP=SPLIT, set split_mask[HMASTER] and force re-arbitration, overriding LOCK.
  - On any edge, clear split_mask[i] where HSPLIT[i]=1.
  - If set and clear hit the same bit on one edge, set wins.
- If all masters are split-masked, grant DEFAULT_MASTER even if it is masked. That master must drive IDLE.
- ERROR/RETRY responses do not alter arbitration state. A RETRY'd master re-requests normally.
- Early burst termination at a NONSEQ first beat is permitted. Grant is held across SEQ/BUSY while the owner keeps HBUSREQ.
- Invariant: HGRANT is one-hot every cycle; HMASTER < NO_OF_MASTERS.

Test Plan:
- Reset, then HBUSREQ=0000 for 5 cycles -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 throughout.
- HBUSREQ=1111 constant, HREADY=1, HTRANS=NONSEQ each cycle -> HGRANT rotates 0010,0100,1000,0001; HMASTER follows 1,2,3,0 one cycle later.
- Master 2 granted, HBUSREQ=0110, HTRANS=SEQ for 4 beats with HREADY=0 on beat 2 -> HGRANT stays 0100 until HTRANS=IDLE; HGRANT becomes 0010 on the next HREADY=1 edge.
- Master 1 requests with HLOCK[1]=1, master 3 requesting -> FSM=LOCK; HGRANT=0010 and HMASTLOCK=1 held until HLOCK[1] drops; master 3 granted at the next HREADY=1 edge.
- HMASTER=2, HRESP=SPLIT with HREADY=1, HBUSREQ=0100 -> split_mask=0100, HGRANT=0001 (default). Later HSPLIT=0100 -> master 2 granted at the next arbitration point.
- Same-edge HRESP=SPLIT for HMASTER=1 and HSPLIT[1]=1 -> split_mask[1]=1 (set wins); master 1 not granted.
